// File: rtl/id_ex_stage.sv
// ID/EX pipeline register built as a 2-entry skid buffer. The main entry drives the ALU.
// InReady is decoded from registered state only, so OutReady has no combinational path to it.
module id_ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] InSrcA,
    input  logic [DATA_W-1:0] InSrcB,
    input  logic [2:0]        InALUControl,
    input  logic [4:0]        InRd,
    input  logic              InRegWrite,
    input  logic              Flush,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] SrcA,
    output logic [DATA_W-1:0] SrcB,
    output logic [2:0]        ALUControl,
    output logic [4:0]        Rd,
    output logic              RegWrite
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] src_a;
        logic [DATA_W-1:0] src_b;
        logic [2:0]        alu_ctl;
        logic [4:0]        rd;
        logic              reg_write;
    } bundle_t;

    state_t  state, state_nxt;
    bundle_t main_q, main_nxt;
    bundle_t skid_q, skid_nxt;
    bundle_t in_bundle;
    logic    acc, rel;

    assign in_bundle = '{src_a: InSrcA, src_b: InSrcB, alu_ctl: InALUControl,
                         rd: InRd, reg_write: InRegWrite};

    assign InReady  = (state != FULL);
    assign OutValid = (state != EMPTY);
    assign acc      = InValid & InReady;
    assign rel      = OutValid & OutReady;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        case (state)
            EMPTY: begin
                if (acc) begin
                    state_nxt = ONE;
                    main_nxt  = in_bundle;
                end
            end
            ONE: begin
                if (acc && rel) begin
                    main_nxt = in_bundle;
                end else if (acc) begin
                    state_nxt = FULL;
                    skid_nxt  = in_bundle;
                end else if (rel) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (rel) begin
                    state_nxt = ONE;
                    main_nxt  = skid_q;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush wins over any accept/release; payload contents are don't-care once EMPTY
        if (Flush) state_nxt = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    assign SrcA       = main_q.src_a;
    assign SrcB       = main_q.src_b;
    assign ALUControl = main_q.alu_ctl;
    assign Rd         = main_q.rd;
    // A stale main entry must never cause a register-file write
    assign RegWrite   = main_q.reg_write & OutValid;

endmodule
